// File: rtl/prefix_adder_pipe_if.sv
// Stream interface for prefix_adder_pipe: operation request channel, result channel
// and the accumulator readback.
interface prefix_adder_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             op_sub;
    logic             op_acc;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [WIDTH-1:0] acc_q;

    modport master (
        output in_valid, a_in, b_in, cin, op_sub, op_acc, acc_clr, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, acc_q
    );

    modport slave (
        input  in_valid, a_in, b_in, cin, op_sub, op_acc, acc_clr, out_ready,
        output in_ready, out_valid, sum, cout, ovf, acc_q
    );
endinterface

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone prefix adder with add/sub/accumulate modes and a
// valid/ready stream on both sides; tree levels are spread over STAGES registers.
module prefix_adder_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int ACC_EN = 1
) (
    input logic               wb_clk_i,
    input logic               wb_rst_i,
    prefix_adder_pipe_if.slave bus
);
    localparam int LEVELS = $clog2(WIDTH);

    typedef struct packed {
        logic             valid;
        logic             isAcc;
        logic             c;
        logic             xMsb;
        logic             yMsb;
        logic [WIDTH-1:0] pBit;
        logic [WIDTH-1:0] grpG;
        logic [WIDTH-1:0] grpP;
    } stageT;

    // Applies prefix levels [lo, hi) of the (G,P) combine tree.
    function automatic stageT combineLevels(input stageT s, input int lo, input int hi);
        stageT            r;
        logic [WIDTH-1:0] gPrev;
        logic [WIDTH-1:0] pPrev;
        r = s;
        for (int l = 0; l < LEVELS; l++) begin
            if (l >= lo && l < hi) begin
                gPrev = r.grpG;
                pPrev = r.grpP;
                for (int i = 0; i < WIDTH; i++) begin
                    if (i >= (1 << l)) begin
                        r.grpG[i] = gPrev[i] | (pPrev[i] & gPrev[i - (1 << l)]);
                        r.grpP[i] = pPrev[i] & pPrev[i - (1 << l)];
                    end
                end
            end
        end
        return r;
    endfunction

    logic             en;
    logic             accHazard;
    stageT            front;
    stageT            src  [STAGES];
    stageT            post [STAGES];
    logic [WIDTH-1:0] resultSum;
    logic             resultCout;
    logic             resultOvf;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             outValid_q, outValid_d;
    logic             outAcc_q, outAcc_d;
    logic [WIDTH-1:0] accum_q, accum_d;

    assign en           = !outValid_q | bus.out_ready;
    assign bus.in_ready = en & !accHazard;

    // Carry-in is folded into bit-0 generate so the tree output is the carry vector.
    always_comb begin : opForm
        logic             useAcc;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] yRaw;
        logic [WIDTH-1:0] y;
        logic             c;
        useAcc     = (ACC_EN != 0) && bus.op_acc;
        x          = useAcc ? accum_q : bus.a_in;
        yRaw       = useAcc ? bus.a_in : bus.b_in;
        y          = bus.op_sub ? ~yRaw : yRaw;
        c          = bus.op_sub | bus.cin;
        front       = '0;
        front.valid = bus.in_valid & bus.in_ready;
        front.isAcc = useAcc;
        front.c     = c;
        front.xMsb  = x[WIDTH-1];
        front.yMsb  = y[WIDTH-1];
        front.pBit  = x ^ y;
        front.grpG  = x & y;
        front.grpG[0] = (x[0] & y[0]) | ((x[0] ^ y[0]) & c);
        front.grpP  = x ^ y;
    end

    assign src[0] = front;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = (s * LEVELS) / STAGES;
        localparam int HI = ((s + 1) * LEVELS) / STAGES;

        assign post[s] = combineLevels(src[s], LO, HI);

        if (s > 0) begin : g_reg
            stageT stage_q;
            stageT stage_d;

            assign stage_d = en ? post[s-1] : stage_q;

            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) stage_q <= '0;
                else          stage_q <= stage_d;
            end

            assign src[s] = stage_q;
        end
    end

    // Accumulates are serialised: nothing new enters while one is anywhere in the pipe.
    always_comb begin
        accHazard = outValid_q & outAcc_q;
        for (int s = 1; s < STAGES; s++) begin
            accHazard = accHazard | (src[s].valid & src[s].isAcc);
        end
        if (ACC_EN == 0) accHazard = 1'b0;
    end

    always_comb begin
        resultSum  = post[STAGES-1].pBit ^ {post[STAGES-1].grpG[WIDTH-2:0], post[STAGES-1].c};
        resultCout = post[STAGES-1].grpG[WIDTH-1];
        resultOvf  = (post[STAGES-1].xMsb == post[STAGES-1].yMsb) &&
                     (resultSum[WIDTH-1] != post[STAGES-1].xMsb);
        sum_d      = sum_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        outValid_d = outValid_q;
        outAcc_d   = outAcc_q;
        if (en) begin
            outValid_d = post[STAGES-1].valid;
            outAcc_d   = post[STAGES-1].isAcc;
            if (post[STAGES-1].valid) begin
                sum_d  = resultSum;
                cout_d = resultCout;
                ovf_d  = resultOvf;
            end
        end
        // A clear in the same cycle as an accumulate write-back takes priority.
        accum_d = accum_q;
        if (ACC_EN == 0)                                   accum_d = '0;
        else if (bus.acc_clr)                              accum_d = '0;
        else if (outValid_q & bus.out_ready & outAcc_q)    accum_d = sum_q;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            outValid_q <= 1'b0;
            outAcc_q   <= 1'b0;
            accum_q    <= '0;
        end else begin
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
            outValid_q <= outValid_d;
            outAcc_q   <= outAcc_d;
            accum_q    <= accum_d;
        end
    end

    assign bus.out_valid = outValid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.acc_q     = accum_q;
endmodule
